// File: rtl/axil_weight_loader.sv
// -----------------------------------------------------------------------------
// axil_weight_loader
//
// Streams 16-bit synaptic weights into a memory-mapped weight store over an
// AXI4-Lite master write port. Each weight goes to base_addr + 4*index as a
// 32-bit word with only the low two byte lanes enabled. Only one write is ever
// outstanding: the next weight is not fetched until the B response of the
// previous write has been received. An error response aborts the load, sets
// the sticky error flag and records the failing index.
//
// Optional build feature (macro AXIL_WLOAD_READBACK_EN):
//   After every successful write the word is read back over the AXI4-Lite
//   read port and compared. A mismatch or a non-OKAY read response aborts the
//   load like a write error. With the macro undefined the read port is tied
//   to zero and its inputs are ignored.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              one-cycle load request, accepted only when idle
//   base_addr, count   byte address of weight 0 and number of weights,
//                      sampled when start is accepted
//   w_data/w_valid/w_ready   incoming weight stream
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4-Lite write channels (master)
//   m_axi_ar*, m_axi_r*             AXI4-Lite read channels (master)
//   busy               high in every state except idle
//   done               one-cycle pulse at the end of every load
//   error, err_index   sticky failure flag and index of the failing weight
// -----------------------------------------------------------------------------
module axil_weight_loader #(
    parameter int COUNT_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] count,
    input  logic [15:0]        w_data,
    input  logic               w_valid,
    output logic               w_ready,
    output logic [31:0]        m_axi_awaddr,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic [31:0]        m_axi_wdata,
    output logic [3:0]         m_axi_wstrb,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    input  logic [1:0]         m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,
    output logic [31:0]        m_axi_araddr,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [31:0]        m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] err_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_RESP,
`ifdef AXIL_WLOAD_READBACK_EN
        S_READ,
        S_RDATA,
`endif
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [31:0]        base_r;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] index_r;
    logic [COUNT_W-1:0] index_inc;
    logic               last;
    logic               aw_done;    // AW handshake already completed this write
    logic               w_done;     // W handshake already completed this write
    logic               aw_fin;
    logic               w_fin;
    logic               advance;    // current weight finished cleanly
    logic               fail;       // current weight failed, abort the load

    assign index_inc = index_r + 1'b1;
    assign last      = (index_inc == count_r);

    // A channel is finished once its handshake happens now or happened earlier.
    assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_nx = state;
        advance  = 1'b0;
        fail     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_valid) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (aw_fin && w_fin) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        fail = 1'b1;
                    end else begin
`ifdef AXIL_WLOAD_READBACK_EN
                        state_nx = S_READ;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
`ifdef AXIL_WLOAD_READBACK_EN
            S_READ: begin
                if (m_axi_arready) begin
                    state_nx = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    // The written word is still held on wdata, so compare to it.
                    if (m_axi_rresp == 2'b00 && m_axi_rdata == m_axi_wdata) begin
                        advance = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (fail) begin
            state_nx = S_DONE;
        end else if (advance) begin
            state_nx = last ? S_DONE : S_FETCH;
        end
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Handshake outputs are decoded from the
    // next state so each one is valid in the first cycle of its state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register is reset here, including address and data,
            // because all outputs must read zero straight after reset.
            state         <= S_IDLE;
            base_r        <= '0;
            count_r       <= '0;
            index_r       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            w_ready       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_index     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state         <= state_nx;
            busy          <= (state_nx != S_IDLE);
            done          <= (state_nx == S_DONE);
            w_ready       <= (state_nx == S_FETCH);
            m_axi_bready  <= (state_nx == S_RESP);

            // Each valid drops the cycle after its own handshake.
            m_axi_awvalid <= (state_nx == S_WRITE) && !aw_fin;
            m_axi_wvalid  <= (state_nx == S_WRITE) && !w_fin;
            aw_done       <= (state_nx == S_WRITE) && aw_fin;
            w_done        <= (state_nx == S_WRITE) && w_fin;

            if (state == S_IDLE && start) begin
                base_r  <= base_addr;
                count_r <= count;
                index_r <= '0;
                error   <= 1'b0;
            end

            if (state == S_FETCH && w_valid) begin
                // 32-bit add wraps naturally past 0xFFFFFFFC.
                m_axi_awaddr <= base_r + (32'(index_r) << 2);
                m_axi_wdata  <= {16'h0000, w_data};
                m_axi_wstrb  <= 4'b0011;
            end

            if (advance) begin
                index_r <= index_inc;
            end

            if (fail) begin
                error     <= 1'b1;
                err_index <= index_r;
            end
        end
    end

`ifdef AXIL_WLOAD_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            m_axi_arvalid <= (state_nx == S_READ);
            m_axi_rready  <= (state_nx == S_RDATA);
            if (state == S_RESP && state_nx == S_READ) begin
                m_axi_araddr <= m_axi_awaddr;
            end
        end
    end
`else
    assign m_axi_araddr  = '0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;

    // Read-channel inputs have no function without readback.
    logic rd_unused;
    assign rd_unused = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule

// File: tb/tb_axil_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_axil_weight_loader
//
// Directed self-checking bench for axil_weight_loader. A negedge-driven slave
// model answers the AXI4-Lite channels with programmable AW/W ready delays,
// an optional error response on a chosen write and an optional corrupted
// readback word; a stream source feeds weights from a queue and can stall.
// Each step of the initial block applies one scenario and compares against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_axil_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [16:0] count;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        busy;
    logic        done;
    logic        error;
    logic [16:0] err_index;

    always #5 clk = ~clk;

    axil_weight_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .w_data        (w_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_index     (err_index)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- stream source and slave model state -------------------
    logic [15:0] wq[$];
    int          widx       = 0;
    logic        w_take     = 1'b0;
    logic        stall      = 1'b0;
    int          aw_delay   = 0;
    int          w_delay    = 0;
    int          aw_cnt     = 0;
    int          w_cnt      = 0;
    int          err_at     = -1;
    int          rd_corrupt = 0;
    logic        aw_got     = 1'b0;
    logic        w_got      = 1'b0;
    int          b_n        = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] aw_log[$];
    logic [31:0] wd_log[$];
    logic [3:0]  ws_log[$];
    logic [31:0] ar_log[$];
    int          aw_hi      = 0;
    int          w_hi       = 0;
    int          busy_cyc   = 0;
    int          done_cnt   = 0;
    int          wr_cyc     = 0;

    initial begin
        w_valid       = 1'b0;
        w_data        = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
    end

    // Everything here changes on the falling edge, so the DUT sees stable
    // inputs at the rising edge; a handshake seen here completes at the next
    // rising edge and is logged now.
    always @(negedge clk) begin
        if (w_take) widx++;
        w_valid = !stall && (widx < wq.size());
        w_data  = (widx < wq.size()) ? wq[widx] : 16'h0000;
        w_take  = w_valid && w_ready;

        if (m_axi_awvalid) begin
            aw_hi++;
            m_axi_awready = (aw_cnt >= aw_delay);
            aw_cnt++;
        end else begin
            m_axi_awready = 1'b0;
            aw_cnt = 0;
        end
        if (m_axi_awvalid && m_axi_awready) begin
            aw_log.push_back(m_axi_awaddr);
            aw_got = 1'b1;
        end

        if (m_axi_wvalid) begin
            w_hi++;
            m_axi_wready = (w_cnt >= w_delay);
            w_cnt++;
        end else begin
            m_axi_wready = 1'b0;
            w_cnt = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            wd_log.push_back(m_axi_wdata);
            ws_log.push_back(m_axi_wstrb);
            last_wdata = m_axi_wdata;
            w_got = 1'b1;
        end

        if (m_axi_bvalid) begin
            m_axi_bvalid = 1'b0;
        end else if (aw_got && w_got && m_axi_bready) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_n == err_at) ? 2'b10 : 2'b00;
            b_n++;
            aw_got = 1'b0;
            w_got  = 1'b0;
        end

        if (m_axi_arready) begin
            m_axi_arready = 1'b0;
        end else if (m_axi_arvalid) begin
            m_axi_arready = 1'b1;
            ar_log.push_back(m_axi_araddr);
        end

        if (m_axi_rvalid) begin
            m_axi_rvalid = 1'b0;
        end else if (m_axi_rready) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = last_wdata + 32'(rd_corrupt);
            m_axi_rresp  = 2'b00;
        end

        if (busy)    busy_cyc++;
        if (done)    done_cnt++;
        if (w_ready) wr_cyc++;
    end

    task automatic clear_logs();
        aw_log.delete();
        wd_log.delete();
        ws_log.delete();
        ar_log.delete();
        widx     = 0;
        w_take   = 1'b0;
        b_n      = 0;
        aw_hi    = 0;
        w_hi     = 0;
        busy_cyc = 0;
        done_cnt = 0;
        wr_cyc   = 0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [16:0] c);
        @(negedge clk);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),          32'h0);
        check("rst_done",      32'(done),          32'h0);
        check("rst_error",     32'(error),         32'h0);
        check("rst_err_index", 32'(err_index),     32'h0);
        check("rst_awvalid",   32'(m_axi_awvalid), 32'h0);
        check("rst_wvalid",    32'(m_axi_wvalid),  32'h0);
        check("rst_bready",    32'(m_axi_bready),  32'h0);
        check("rst_w_ready",   32'(w_ready),       32'h0);
        check("rst_arvalid",   32'(m_axi_arvalid), 32'h0);
        check("rst_rready",    32'(m_axi_rready),  32'h0);
        check("rst_awaddr",    m_axi_awaddr,       32'h0);
        check("rst_wdata",     m_axi_wdata,        32'h0);
        check("rst_araddr",    m_axi_araddr,       32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- three weights, zero-wait slave ----------------
        clear_logs();
        wq = '{16'h0011, 16'h0022, 16'h0033};
        pulse_start(32'h0000_0100, 17'd3);
        wait_idle("a_timeout", 200);
        check("a_nwrites", 32'(aw_log.size()), 32'd3);
        check("a_addr0",   aw_log[0], 32'h0000_0100);
        check("a_addr1",   aw_log[1], 32'h0000_0104);
        check("a_addr2",   aw_log[2], 32'h0000_0108);
        check("a_wdata0",  wd_log[0], 32'h0000_0011);
        check("a_wdata1",  wd_log[1], 32'h0000_0022);
        check("a_wdata2",  wd_log[2], 32'h0000_0033);
        check("a_wstrb0",  32'(ws_log[0]), 32'h3);
        check("a_wstrb2",  32'(ws_log[2]), 32'h3);
        check("a_done",    32'(done_cnt), 32'd1);
        check("a_error",   32'(error), 32'h0);
`ifdef AXIL_WLOAD_READBACK_EN
        // FETCH, WRITE, RESP, READ, RDATA per weight, plus one DONE cycle.
        check("a_busy_cycles", 32'(busy_cyc), 32'd16);
        check("a_nreads",  32'(ar_log.size()), 32'd3);
        check("a_raddr2",  ar_log[2], 32'h0000_0108);
`else
        // FETCH, WRITE, RESP per weight, plus one DONE cycle.
        check("a_busy_cycles", 32'(busy_cyc), 32'd10);
        check("a_nreads",  32'(ar_log.size()), 32'd0);
        check("a_araddr",  m_axi_araddr, 32'h0);
`endif

        // ---------------- awready delayed two cycles ----------------
        clear_logs();
        aw_delay = 2;
        wq = '{16'h0044};
        pulse_start(32'h0000_0200, 17'd1);
        wait_idle("b_timeout", 200);
        check("b_aw_cycles", 32'(aw_hi), 32'd3);
        check("b_w_cycles",  32'(w_hi),  32'd1);
        check("b_nwrites",   32'(aw_log.size()), 32'd1);
        check("b_nwdata",    32'(wd_log.size()), 32'd1);
        check("b_addr0",     aw_log[0], 32'h0000_0200);
        aw_delay = 0;

        // ---------------- error on the second write ----------------
        clear_logs();
        err_at = 1;
        wq = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        pulse_start(32'h0000_0300, 17'd4);
        wait_idle("c_timeout", 200);
        check("c_nwrites",   32'(aw_log.size()), 32'd2);
        check("c_error",     32'(error), 32'h1);
        check("c_err_index", 32'(err_index), 32'd1);
        check("c_done",      32'(done_cnt), 32'd1);
        err_at = -1;
        repeat (5) @(negedge clk);
        check("c_error_sticky", 32'(error), 32'h1);

        // ---------------- count zero ----------------
        clear_logs();
        wq.delete();
        pulse_start(32'h0000_0400, 17'd0);
        wait_idle("d_timeout", 20);
        check("d_done",        32'(done_cnt), 32'd1);
        check("d_busy_cycles", 32'(busy_cyc), 32'd1);
        check("d_aw_cycles",   32'(aw_hi),    32'd0);
        check("d_wready_cyc",  32'(wr_cyc),   32'd0);
        check("d_error_clear", 32'(error),    32'h0);

        // ---------------- address wrap ----------------
        clear_logs();
        wq = '{16'h00AA, 16'h00BB};
        pulse_start(32'hFFFF_FFFC, 17'd2);
        wait_idle("e_timeout", 200);
        check("e_nwrites", 32'(aw_log.size()), 32'd2);
        check("e_addr0",   aw_log[0], 32'hFFFF_FFFC);
        check("e_addr1",   aw_log[1], 32'h0000_0000);
        check("e_wdata1",  wd_log[1], 32'h0000_00BB);

        // ---------------- stream stall, start ignored while busy ----------------
        clear_logs();
        stall = 1'b1;
        wq = '{16'h005A};
        pulse_start(32'h0000_0500, 17'd1);
        repeat (20) @(negedge clk);
        check("f_busy_stall",   32'(busy),    32'h1);
        check("f_wready_stall", 32'(w_ready), 32'h1);
        check("f_no_write",     32'(aw_log.size()), 32'd0);
        pulse_start(32'h0000_0900, 17'd5);
        stall = 1'b0;
        wait_idle("f_timeout", 200);
        check("f_nwrites", 32'(aw_log.size()), 32'd1);
        check("f_addr0",   aw_log[0], 32'h0000_0500);
        check("f_wdata0",  wd_log[0], 32'h0000_005A);
        check("f_done",    32'(done_cnt), 32'd1);

`ifdef AXIL_WLOAD_READBACK_EN
        // ---------------- readback mismatch ----------------
        clear_logs();
        rd_corrupt = 1;
        wq = '{16'h0054};
        pulse_start(32'h0000_0600, 17'd1);
        wait_idle("g_timeout", 200);
        check("g_raddr0",    ar_log[0], 32'h0000_0600);
        check("g_error",     32'(error), 32'h1);
        check("g_err_index", 32'(err_index), 32'd0);
        check("g_done",      32'(done_cnt), 32'd1);
        rd_corrupt = 0;
`endif

        // ---------------- reset in the middle of a write ----------------
        clear_logs();
        aw_delay = 1000;
        wq = '{16'h0077};
        pulse_start(32'h0000_0700, 17'd1);
        for (int i = 0; i < 20; i++) begin
            if (m_axi_awvalid) break;
            @(negedge clk);
        end
        check("h_in_write", 32'(m_axi_awvalid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("h_awvalid", 32'(m_axi_awvalid), 32'h0);
        check("h_wvalid",  32'(m_axi_wvalid),  32'h0);
        check("h_bready",  32'(m_axi_bready),  32'h0);
        check("h_w_ready", 32'(w_ready),       32'h0);
        check("h_busy",    32'(busy),          32'h0);
        rst = 1'b0;
        aw_delay = 0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
